// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC transmitter and receiver.
package cdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cdc_state_t;

    localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_chain.sv
// N-flop synchronizer for a single-bit level or toggle crossing into clk.
module cdc_sync_chain
    import cdc_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    generate
        if (STAGES < CDC_MIN_SYNC_STAGES) begin : g_stages_check
            $error("cdc_sync_chain: STAGES below minimum synchronizer depth");
        end
    endgenerate

    // d lands only in sync_q[0]; every later flop sees a clk-domain signal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit side of a two-phase toggle handshake: launches a held word and waits for the ack phase to match.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack_async,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam bit              TO_EN    = (TIMEOUT > 0);
    localparam int              CNT_W    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = TO_EN ? CNT_W'(TIMEOUT) : '0;
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    cdc_state_t       state;
    logic             ack_s;
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;

    generate
        if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_sync_check
            $error("cdc_handshake_tx: SYNC_STAGES below minimum synchronizer depth");
        end
    endgenerate

    cdc_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (xfer_ack_async),
        .q   (ack_s)
    );

    assign in_ready = (state == IDLE);
    assign to_hit   = TO_EN && (state == WAIT) && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            xfer_req   <= 1'b0;
            xfer_data  <= '0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xfer_data <= in_data;
                        xfer_req  <= ~xfer_req;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Phase equality means the receiver has taken the word
                    if (ack_s == xfer_req) begin
                        busy       <= 1'b0;
                        done_pulse <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Timeout only flags; leaving WAIT early would strand an unanswered toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt != CNT_MAX) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomised scenario bench for cdc_handshake_tx with a phase-tracking reference model and receiver stand-in.
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          xfer_req;
    logic [DW-1:0] xfer_data;
    logic          xfer_ack_async;
    logic          busy;
    logic          done_pulse;
    logic          timeout_err;
    logic          err_clr;

    logic ack_man;
    logic echo_en;
    logic exp_req;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Receiver stand-in: either echoes the request at once or follows a bench-driven phase
    assign xfer_ack_async = echo_en ? xfer_req : ack_man;

    cdc_handshake_tx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .xfer_req       (xfer_req),
        .xfer_data      (xfer_data),
        .xfer_ack_async (xfer_ack_async),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and hold it until the handshake completes; the model phase flips on acceptance
    task automatic offer(input logic [DW-1:0] w, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (ok) exp_req = ~exp_req;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done_pulse) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        echo_en = 1'b0; ack_man = 1'b0; exp_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (xfer_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", xfer_req); end
        checks++; if (xfer_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", xfer_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done_pulse !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_pulse); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_single();
        bit ok;
        bit stable;
        int n;
        offer(8'hA5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_accept got=0 exp=1"); end
        checks++; if (xfer_req !== exp_req) begin failures++; $display("FAIL single_req got=%b exp=%b", xfer_req, exp_req); end
        checks++; if (xfer_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", xfer_data); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL single_busy got=%b/%b exp=1/0", busy, in_ready); end
        stable = 1'b1;
        repeat (4) begin
            tick();
            if (xfer_data !== 8'hA5 || busy !== 1'b1 || done_pulse !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin failures++; $display("FAIL single_hold got=0 exp=1"); end
        ack_man = exp_req;
        wait_done(n);
        checks++; if (n != SS + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", n, SS + 1); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_at_done got=%b exp=1", in_ready); end
        checks++; if (xfer_data !== 8'hA5) begin failures++; $display("FAIL single_data_done got=%h exp=a5", xfer_data); end
        tick();
        checks++; if (done_pulse !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", done_pulse); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w [3];
        int  idx;
        int  dones;
        int  last;
        bit  pre;
        bit  stable;
        bit  gap_ok;
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
        idx = 0; dones = 0; last = -1; stable = 1'b1; gap_ok = 1'b1;
        echo_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = w[0];
        for (int cyc = 0; cyc < 80 && (idx < 3 || dones < 3); cyc++) begin
            pre = in_ready && in_valid;
            tick();
            if (done_pulse) dones++;
            if (pre) begin
                exp_req = ~exp_req;
                checks++; if (xfer_data !== w[idx]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", idx, xfer_data, w[idx]); end
                checks++; if (xfer_req !== exp_req) begin failures++; $display("FAIL b2b_req%0d got=%b exp=%b", idx, xfer_req, exp_req); end
                // Echo receiver: 1 capture edge + SS sync/compare edges + 1 accept edge
                if (idx > 0 && cyc - last != SS + 2) gap_ok = 1'b0;
                last = cyc;
                idx++;
                if (idx == 3) in_valid = 1'b0;
                else in_data = w[idx];
            end else if (idx > 0 && busy && xfer_data !== w[idx-1]) begin
                stable = 1'b0;
            end
        end
        in_valid = 1'b0;
        ack_man  = exp_req;
        echo_en  = 1'b0;
        checks++; if (idx != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
        checks++; if (dones != 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
        checks++; if (!stable) begin failures++; $display("FAIL b2b_stable got=0 exp=1"); end
        checks++; if (!gap_ok) begin failures++; $display("FAIL b2b_spacing got=0 exp=1"); end
    endtask

    task automatic test_busy_stall();
        bit ok;
        int n;
        offer(8'h3C, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_accept got=0 exp=1"); end
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        checks++; if (xfer_data !== 8'h3C) begin failures++; $display("FAIL stall_data got=%h exp=3c", xfer_data); end
        ack_man = exp_req;
        wait_done(n);
        checks++; if (n != SS + 1) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", n, SS + 1); end
        checks++; if (in_ready !== 1'b1 || xfer_data !== 8'h3C) begin failures++; $display("FAIL stall_done got=%b/%h exp=1/3c", in_ready, xfer_data); end
        tick();
        exp_req  = ~exp_req;
        in_valid = 1'b0;
        checks++; if (xfer_data !== 8'h77) begin failures++; $display("FAIL stall_next_data got=%h exp=77", xfer_data); end
        checks++; if (xfer_req !== exp_req) begin failures++; $display("FAIL stall_next_req got=%b exp=%b", xfer_req, exp_req); end
        ack_man = exp_req;
        wait_done(n);
        checks++; if (n != SS + 1) begin failures++; $display("FAIL stall_next_latency got=%0d exp=%0d", n, SS + 1); end
    endtask

    task automatic test_random();
        bit            ok;
        bit            stable;
        int            n;
        logic [DW-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w = DW'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            offer(w, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_accept got=0 exp=1", k); end
            checks++; if (xfer_data !== w || xfer_req !== exp_req) begin failures++; $display("FAIL rnd%0d_launch got=%h/%b exp=%h/%b", k, xfer_data, xfer_req, w, exp_req); end
            stable = 1'b1;
            repeat ($urandom_range(0, 5)) begin
                tick();
                if (xfer_data !== w || busy !== 1'b1) stable = 1'b0;
            end
            checks++; if (!stable) begin failures++; $display("FAIL rnd%0d_hold got=0 exp=1", k); end
            ack_man = exp_req;
            wait_done(n);
            checks++; if (n != SS + 1) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, n, SS + 1); end
        end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rnd_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit early;
        int n;
        offer(8'h5A, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_accept got=0 exp=1"); end
        early = 1'b0;
        repeat (TO - 1) begin
            tick();
            if (timeout_err !== 1'b0) early = 1'b1;
        end
        checks++; if (early) begin failures++; $display("FAIL to_early got=1 exp=0"); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", timeout_err); end
        repeat (5) tick();
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_stay got=%b/%b exp=1/1", busy, timeout_err); end
        ack_man = exp_req;
        wait_done(n);
        checks++; if (n != SS + 1) begin failures++; $display("FAIL to_late_ack got=%0d exp=%0d", n, SS + 1); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
        offer(8'h96, ok);
        repeat (TO - 1) tick();
        err_clr = 1'b1;
        tick();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_set_wins got=%b exp=1", timeout_err); end
        err_clr = 1'b0;
        tick();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_no_reset got=%b exp=1", timeout_err); end
        ack_man = exp_req;
        wait_done(n);
        checks++; if (n != SS + 1) begin failures++; $display("FAIL to_late_ack2 got=%0d exp=%0d", n, SS + 1); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit seen;
        offer(8'hC3, ok);
        checks++; if (!ok || busy !== 1'b1) begin failures++; $display("FAIL mid_launch got=%b exp=1", busy); end
        repeat (2) tick();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b/%b exp=1/0", in_ready, busy); end
        checks++; if (xfer_req !== 1'b0 || xfer_data !== 8'h00) begin failures++; $display("FAIL mid_regs got=%b/%h exp=0/00", xfer_req, xfer_data); end
        ack_man = 1'b0;
        exp_req = 1'b0;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (done_pulse !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL mid_no_done got=1 exp=0"); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_after got=%b/%b exp=1/0", in_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_stall();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source (transmit) end of a two-phase toggle handshake that carries a DATA_W-bit word out of the local `clk` domain into an unrelated receiving domain. It accepts a word over a local valid/ready port, holds it stable on `xfer_data`, toggles `xfer_req`, and waits for the receiver's acknowledge toggle, which it resynchronises internally before releasing the word. It pairs with a receiver that samples `xfer_req` through its own multi-flop synchronizer.

## Interface
Parameters:
- DATA_W, 8, width of the transferred word (≥1)
- SYNC_STAGES, 2, flops in the ack synchronizer chain (≥2)
- TIMEOUT, 0, cycles in WAIT before `timeout_err` sets; 0 disables the timeout logic

Ports:
- clk  input  1  single clock for the block
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  local word offered
- in_ready  output  1  block can accept; high exactly when state is IDLE
- in_data  input  DATA_W  local word
- xfer_req  output  1  request toggle, driven straight from a flop, glitch-free
- xfer_data  output  DATA_W  registered word, stable from launch until release
- xfer_ack_async  input  1  acknowledge toggle from the receiver domain, unsynchronised
- busy  output  1  high in WAIT
- done_pulse  output  1  one-cycle pulse when a transfer completes
- timeout_err  output  1  sticky timeout flag
- err_clr  input  1  clears `timeout_err`

## Operation
Reset values:
- `xfer_req`=0, `xfer_data`=0, `busy`=0, `done_pulse`=0, `timeout_err`=0
- State is IDLE, so `in_ready`=1
- Sync flops and timeout counter are 0

States:
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, the block captures `in_data` into `xfer_data`, inverts `xfer_req` and goes to WAIT.
- WAIT: `in_ready`=0, `busy`=1. `ack_s` is the synchronised `xfer_ack_async`. When `ack_s`==`xfer_req`, the block returns to IDLE and registers `done_pulse`=1 for one cycle.
- `xfer_data` never changes outside the IDLE accept edge.

Timeout (TIMEOUT>0):
- The counter clears on entry to WAIT and increments each WAIT cycle, saturating at TIMEOUT.
- When it reaches TIMEOUT, `timeout_err` sets.
- The FSM stays in WAIT. Abandoning a launched toggle would desynchronise the phases.
- `err_clr` clears `timeout_err`. If set and clear occur in the same cycle, set wins.
- A late ack still completes normally. `timeout_err` stays set until cleared.

Boundary conditions:
- `in_valid` while busy is ignored. The word is not consumed, and the upstream holds it per valid/ready rules.
- Back-to-back: `in_ready` is high in the `done_pulse` cycle, so a held `in_valid` is accepted there. Two `xfer_req` toggles are never closer than a full round trip.
- Ack toggles with no outstanding request (`ack_s`!=`xfer_req` while IDLE) are ignored. The next launch then completes on phase equality; see the reset rule.
- Reset mid-WAIT returns the block to IDLE with `xfer_req`=0. The system must reset the receiver's ack toggle in the same reset event; mismatched reset is a system-level error, not detected here.

## Timing
- Accept at edge N: `xfer_req` and `xfer_data` change just after N.
- The ack transition is first captured at edge M. `ack_s` updates after edge M+SYNC_STAGES-1.
- The FSM leaves WAIT at edge M+SYNC_STAGES. `done_pulse` and `in_ready` are high in the following cycle.
- No combinational path from any input to `xfer_req` or `xfer_data`.
- `xfer_ack_async` feeds only the first synchronizer flop.
- `in_ready` is decoded from the state register only, never from `in_valid`.

## Structure
- Shared package `cdc_pkg`: state typedef (IDLE, WAIT) and a `CDC_MIN_SYNC_STAGES`=2 constant, reused by the receiver.
- Sub-module `cdc_sync_chain`: parameterised N-flop synchronizer (`clk`, `rst`, `d`, `q`), reset to 0. Instantiate it once for the ack.
- Elaboration-time check: SYNC_STAGES ≥ `CDC_MIN_SYNC_STAGES`.

## Test plan
- Reset then idle: assert `rst` for 3 cycles with `in_valid`=0 → `xfer_req`=0, `xfer_data`=0, `in_ready`=1, `busy`=0, all flags 0.
- Single transfer: send `in_data`=0xA5, then toggle the ack 5 cycles later (SYNC_STAGES=2) → `xfer_req` rises after the accept edge, `xfer_data`=0xA5 held throughout, `done_pulse` exactly 2 cycles after the ack is first sampled, `in_ready`=1 in the same cycle.
- Back-to-back with `in_valid` held: send 0x01, 0x02, 0x03 with an immediate-echo receiver model → three `xfer_req` toggles (1,0,1), three `done_pulse`s, words seen in order, and no `xfer_data` change while `busy`.
- Busy stall: drive `in_valid` with 0x77 during WAIT → `in_ready`=0, `xfer_data` unchanged, and 0x77 is accepted only after `done_pulse`.
- Timeout (TIMEOUT=10): withhold the ack → `timeout_err` sets after 10 WAIT cycles, FSM stays `busy`. A late ack still gives `done_pulse`. `err_clr` then clears the flag; with `err_clr` in the same cycle as the set, the flag remains 1.
- Reset mid-WAIT: assert `rst` while WAIT → immediate IDLE, `xfer_req`=0, `busy`=0, and no `done_pulse` after release.
